dsp_sop_result_drain: RTL and testbench
=======================================

# dsp_sop_result_drain

Serializing drain for the outputs of an 8-lane DSP sum-of-products array. It captures one 296-bit frame (8 lanes × 37 bits) and streams it out one lane per beat over a valid/ready interface, so downstream logic can consume results through a narrow port. In the datapath it sits after the SOP array's packed output bus.

## Interface
Parameters:
- LANES, 8, number of result lanes per frame.
- WIDTH, 37, bits per lane result.

Ports:
- clk  in  1  single clock; all logic rising-edge.
- reset  in  1  synchronous, active-high reset.
- in_data  in  LANES*WIDTH  packed frame; lane k = in_data[k*WIDTH +: WIDTH].
- in_valid  in  1  frame offered.
- in_ready  out  1  drain can accept a frame this cycle.
- out_data  out  WIDTH  current beat payload.
- out_lane  out  4  lane index of current beat (0..LANES-1; LANES for checksum beat).
- out_valid  out  1  beat offered.
- out_ready  in  1  downstream accepts beat.
- out_last  out  1  final beat of frame.
- frame_cnt  out  16  frames fully drained, saturating at 0xFFFF.

## Operation
- States: IDLE, DRAIN.
- IDLE: in_ready=1, out_valid=0. On in_valid&in_ready: capture in_data into frame register, lane pointer←0, go DRAIN.
- DRAIN: out_valid=1, out_data = frame lane[ptr], out_lane=ptr. On out_valid&out_ready: ptr increments. Without out_ready, out_data/out_lane/out_last hold stable (no change while stalled).
- out_last=1 on beat ptr=LANES-1 (or checksum beat when enabled).
- Last-beat accept: frame_cnt increments (saturating); if in_valid also high in same cycle, new frame captured, ptr←0, stay DRAIN (back-to-back, no bubble); otherwise go IDLE.
- in_ready = (state==IDLE) | (state==DRAIN & out_last & out_ready). Combinational from out_ready; documented path.
- in_valid while not ready: ignored; upstream must hold data.
- Reset mid-frame: frame discarded, state IDLE, ptr 0, frame_cnt 0; no partial beat after reset deasserts.

## Timing
- Reset values: in_ready=0 while reset asserted, 1 first cycle after; out_valid=0, out_data=0, out_lane=0, out_last=0, frame_cnt=0.
- Capture to first beat: 1 cycle (frame accepted at edge N, out_valid high after edge N).
- Frame length: LANES beats (LANES+1 with checksum). Sustained throughput with out_ready=1 and in_valid=1: one frame per LANES cycles, zero bubbles.
- Isolated frame: in_ready returns high the cycle after last beat accepted.
- frame_cnt updates on the edge where last beat is accepted.

## Configuration
- DSP_DRAIN_CHECKSUM_EN defined: after lane LANES-1, one extra beat with out_lane=LANES, out_data = XOR of all LANES captured lanes, out_last=1 only on that beat; back-to-back accept moves to that beat.
- Undefined: no checksum beat; out_lane never exceeds LANES-1; checksum logic absent.

## Test plan
- Reset then frame lane k = k+1 (1..8), out_ready=1: beats out_data 1..8, out_lane 0..7, out_last on lane 7 only, frame_cnt=1, in_ready high next cycle.
- out_ready toggles 1/0 each cycle on frame lane k = 0x1F_0000_0000+k: each beat held stable across stall cycles, 16 cycles total, order intact.
- Two frames offered back-to-back (A lanes 0xA0..0xA7, B lanes 0xB0..0xB7), out_ready=1: 16 consecutive valid beats, no gap, frame_cnt=2.
- Reset asserted after third beat: out_valid=0 next cycle, frame_cnt=0, following frame drains from lane 0.
- With DSP_DRAIN_CHECKSUM_EN, lanes 1,2,4,8,16,32,64,128: 9th beat out_lane=8, out_data=0xFF, out_last only there.
- Preload frame_cnt to saturation via 65536 frames (or forced): remains 0xFFFF after further frames.

Source files
------------

// File: rtl/dsp_sop_result_drain.sv
// rtl/dsp_sop_result_drain.sv - captures an 8-lane SOP result frame and streams one lane per beat
// Optional checksum beat (XOR of all lanes) enabled by defining DSP_DRAIN_CHECKSUM_EN.
module dsp_sop_result_drain #(
  parameter int LANES = 8,
  parameter int WIDTH = 37
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [LANES*WIDTH-1:0] in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [WIDTH-1:0]       out_data,
  output logic [3:0]             out_lane,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_last,
  output logic [15:0]            frame_cnt
);

  localparam int IDXW = (LANES > 1) ? $clog2(LANES) : 1;
`ifdef DSP_DRAIN_CHECKSUM_EN
  localparam logic [3:0] LAST_PTR = 4'(LANES);
`else
  localparam logic [3:0] LAST_PTR = 4'(LANES - 1);
`endif

  typedef enum logic {IDLE, DRAIN} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_lane [LANES];
  logic [3:0]       r_ptr;
  logic [15:0]      r_frame_cnt;

  logic             w_at_last;
  logic             w_beat;
  logic             w_last_beat;
  logic             w_accept;
  logic [IDXW-1:0]  w_lane_idx;

  assign w_at_last   = (r_ptr == LAST_PTR);
  assign w_beat      = (r_state == DRAIN) & out_ready;
  assign w_last_beat = w_beat & w_at_last;
  assign w_accept    = in_valid & in_ready;
  assign w_lane_idx  = r_ptr[IDXW-1:0];
  assign frame_cnt   = r_frame_cnt;

`ifdef DSP_DRAIN_CHECKSUM_EN
  logic [WIDTH-1:0] w_csum;

  always_comb begin
    w_csum = '0;
    for (int k = 0; k < LANES; k++) begin
      w_csum = w_csum ^ r_lane[k];
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_nxt = DRAIN;
      DRAIN:   if (w_last_beat) w_state_nxt = w_accept ? DRAIN : IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // in_ready looks straight through to out_ready so a new frame can follow the last beat without a bubble.
  always_comb begin
    in_ready  = ~reset & ((r_state == IDLE) | ((r_state == DRAIN) & w_at_last & out_ready));
    out_valid = (r_state == DRAIN);
    out_lane  = (r_state == DRAIN) ? r_ptr : 4'd0;
    out_last  = (r_state == DRAIN) & w_at_last;
    out_data  = '0;
    if (r_state == DRAIN) begin
`ifdef DSP_DRAIN_CHECKSUM_EN
      out_data = (r_ptr == 4'(LANES)) ? w_csum : r_lane[w_lane_idx];
`else
      out_data = r_lane[w_lane_idx];
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr       <= 4'd0;
      r_frame_cnt <= 16'd0;
    end else begin
      if (w_accept) begin
        r_ptr <= 4'd0;
      end else if (w_beat) begin
        r_ptr <= r_ptr + 4'd1;
      end
      if (w_last_beat && (r_frame_cnt != 16'hFFFF)) begin
        r_frame_cnt <= r_frame_cnt + 16'd1;
      end
    end
  end

  // Frame storage needs no reset: it is only visible while DRAIN, which is entered solely by a capture.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      for (int k = 0; k < LANES; k++) begin
        r_lane[k] <= in_data[k*WIDTH +: WIDTH];
      end
    end
  end

endmodule

// File: tb/tb_dsp_sop_result_drain.sv
// tb/tb_dsp_sop_result_drain.sv - scoreboard bench for dsp_sop_result_drain
module tb_dsp_sop_result_drain;

  localparam int LANES = 8;
  localparam int WIDTH = 37;
`ifdef DSP_DRAIN_CHECKSUM_EN
  localparam int BEATS = LANES + 1;
`else
  localparam int BEATS = LANES;
`endif

  logic                   clk = 1'b0;
  logic                   reset = 1'b1;
  logic [LANES*WIDTH-1:0] in_data = '0;
  logic                   in_valid = 1'b0;
  logic                   in_ready;
  logic [WIDTH-1:0]       out_data;
  logic [3:0]             out_lane;
  logic                   out_valid;
  logic                   out_ready = 1'b1;
  logic                   out_last;
  logic [15:0]            frame_cnt;

  dsp_sop_result_drain #(.LANES(LANES), .WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_lane(out_lane), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errs = 0;

  logic [WIDTH-1:0] q_data [$];
  logic [3:0]       q_lane [$];
  logic             q_last [$];
  logic [WIDTH-1:0] lanes_v [LANES];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  int               ncyc = 0;
  int               vcount = 0;
  int               vfirst = 0;
  int               vlast = 0;
  logic             stalled = 1'b0;
  logic [WIDTH-1:0] s_data;
  logic [3:0]       s_lane;
  logic             s_last;
  logic [WIDTH-1:0] e_data;
  logic [3:0]       e_lane;
  logic             e_last;

  always @(negedge clk) begin
    ncyc++;
    if (reset) begin
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        check("stall_valid", 64'(out_valid), 64'd1);
        check("stall_data", 64'(out_data), 64'(s_data));
        check("stall_lane", 64'(out_lane), 64'(s_lane));
        check("stall_last", 64'(out_last), 64'(s_last));
      end
      if (out_valid) begin
        if (vcount == 0) vfirst = ncyc;
        vlast = ncyc;
        vcount++;
      end
      if (out_valid && out_ready) begin
        if (q_data.size() == 0) begin
          check("unexpected_beat", 64'd1, 64'd0);
        end else begin
          e_data = q_data.pop_front();
          e_lane = q_lane.pop_front();
          e_last = q_last.pop_front();
          check("beat_data", 64'(out_data), 64'(e_data));
          check("beat_lane", 64'(out_lane), 64'(e_lane));
          check("beat_last", 64'(out_last), 64'(e_last));
        end
      end
      stalled = out_valid && !out_ready;
      s_data  = out_data;
      s_lane  = out_lane;
      s_last  = out_last;
    end
  end

  task automatic offer();
    logic [LANES*WIDTH-1:0] d;
    logic [WIDTH-1:0]       x;
    bit                     ok;
    ok = 1'b0;
    x  = '0;
    for (int k = 0; k < LANES; k++) begin
      d[k*WIDTH +: WIDTH] = lanes_v[k];
      x = x ^ lanes_v[k];
    end
    in_data  = d;
    in_valid = 1'b1;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
    end
    if (!ok) begin
      check("offer_timeout", 64'd0, 64'd1);
    end else begin
      for (int k = 0; k < LANES; k++) begin
        q_data.push_back(lanes_v[k]);
        q_lane.push_back(4'(k));
        q_last.push_back((k == LANES - 1) && (BEATS == LANES));
      end
`ifdef DSP_DRAIN_CHECKSUM_EN
      q_data.push_back(x);
      q_lane.push_back(4'(LANES));
      q_last.push_back(1'b1);
`endif
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_q(input int remain);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(posedge clk);
      #2;
      if (q_data.size() <= remain) ok = 1'b1;
    end
    if (!ok) check("drain_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_out_lane", 64'(out_lane), 64'd0);
    check("rst_out_last", 64'(out_last), 64'd0);
    check("rst_frame_cnt", 64'(frame_cnt), 64'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_in_ready", 64'(in_ready), 64'd1);

    // single frame, lanes 1..8
    for (int k = 0; k < LANES; k++) lanes_v[k] = WIDTH'(k + 1);
    offer();
    in_valid = 1'b0;
    wait_q(0);
    check("t1_frame_cnt", 64'(frame_cnt), 64'd1);
    check("t1_in_ready", 64'(in_ready), 64'd1);
    check("t1_out_valid", 64'(out_valid), 64'd0);

    // out_ready toggling, first drain cycle stalled
    out_ready = 1'b0;
    vcount = 0;
    for (int k = 0; k < LANES; k++) lanes_v[k] = 37'h1F_0000_0000 + WIDTH'(k);
    offer();
    in_valid = 1'b0;
    for (int i = 0; i < 2 * BEATS; i++) begin
      out_ready = (i % 2 == 1);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    check("t2_valid_cycles", 64'(vcount), 64'(2 * BEATS));
    check("t2_queue_empty", 64'(q_data.size()), 64'd0);
    check("t2_out_valid", 64'(out_valid), 64'd0);
    check("t2_frame_cnt", 64'(frame_cnt), 64'd2);

    // back-to-back frames A then B
    vcount = 0;
    for (int k = 0; k < LANES; k++) lanes_v[k] = WIDTH'(8'hA0 + k);
    offer();
    for (int k = 0; k < LANES; k++) lanes_v[k] = WIDTH'(8'hB0 + k);
    offer();
    in_valid = 1'b0;
    wait_q(0);
    check("t3_valid_cycles", 64'(vcount), 64'(2 * BEATS));
    check("t3_no_gap", 64'(vlast - vfirst + 1), 64'(2 * BEATS));
    check("t3_frame_cnt", 64'(frame_cnt), 64'd4);

    // reset after the third beat
    for (int k = 0; k < LANES; k++) lanes_v[k] = WIDTH'(12'h100 + k);
    offer();
    in_valid = 1'b0;
    wait_q(BEATS - 3);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("t4_out_valid", 64'(out_valid), 64'd0);
    check("t4_frame_cnt", 64'(frame_cnt), 64'd0);
    check("t4_in_ready", 64'(in_ready), 64'd0);
    q_data.delete();
    q_lane.delete();
    q_last.delete();
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("t4_out_valid_after", 64'(out_valid), 64'd0);
    for (int k = 0; k < LANES; k++) lanes_v[k] = WIDTH'(12'h200 + k);
    offer();
    in_valid = 1'b0;
    wait_q(0);
    check("t4_frame_cnt_after", 64'(frame_cnt), 64'd1);

    // one-hot lanes: checksum beat would be 0xFF
    for (int k = 0; k < LANES; k++) lanes_v[k] = WIDTH'(1) << k;
    offer();
    in_valid = 1'b0;
    wait_q(0);
    check("t5_frame_cnt", 64'(frame_cnt), 64'd2);

    // saturation
    force dut.r_frame_cnt = 16'hFFFD;
    #1;
    release dut.r_frame_cnt;
    check("t6_preload", 64'(frame_cnt), 64'hFFFD);
    for (int f = 0; f < 3; f++) begin
      for (int k = 0; k < LANES; k++) lanes_v[k] = WIDTH'(16'h3000 + 16 * f + k);
      offer();
      in_valid = 1'b0;
      wait_q(0);
      check("t6_frame_cnt", 64'(frame_cnt), (f == 0) ? 64'hFFFE : 64'hFFFF);
    end

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
